// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with legality check and 4-entry output FIFO
module instr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_class,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7b5,
   input  logic [20:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        err_pulse,
   output logic [7:0]  err_count,
   output logic [2:0]  level
);

   localparam logic [2:0] CLS_LW   = 3'd0;
   localparam logic [2:0] CLS_SW   = 3'd1;
   localparam logic [2:0] CLS_R    = 3'd2;
   localparam logic [2:0] CLS_BEQ  = 3'd3;
   localparam logic [2:0] CLS_IALU = 3'd4;
   localparam logic [2:0] CLS_JAL  = 3'd5;

   logic [31:0] mem_q [4];
   logic [31:0] mem_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  level_q, level_d;
   logic        err_pulse_q, err_pulse_d;
   logic [7:0]  err_count_q, err_count_d;

   logic [31:0] enc_word;
   logic        enc_legal;
   logic        is_shift;
   logic        fits12;
   logic        fits13;
   logic        accept;
   logic        push;
   logic        pop;

   assign in_ready  = (level_q < 3'd4);
   assign out_valid = (level_q != 3'd0);
   assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign level     = level_q;

   // A signed value fits in N bits when all bits from N-1 upward agree.
   assign fits12   = (&in_imm[20:11]) | ~(|in_imm[20:11]);
   assign fits13   = (&in_imm[20:12]) | ~(|in_imm[20:12]);
   assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b0;
      case (in_class)
         CLS_LW: begin
            enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            enc_legal = fits12;
         end
         CLS_SW: begin
            enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            enc_legal = fits12;
         end
         CLS_R: begin
            enc_word  = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            enc_legal = 1'b1;
         end
         CLS_BEQ: begin
            enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                         in_imm[4:1], in_imm[11], 7'b1100011};
            enc_legal = fits13 && !in_imm[0];
         end
         CLS_IALU: begin
            if (is_shift) begin
               enc_word  = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3,
                            in_rd, 7'b0010011};
               enc_legal = ~(|in_imm[20:5]);
            end else begin
               enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
               enc_legal = fits12;
            end
         end
         CLS_JAL: begin
            enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            enc_legal = !in_imm[0];
         end
         default: begin
            enc_word  = 32'h0;
            enc_legal = 1'b0;
         end
      endcase
   end

   assign accept = in_valid && in_ready;
   assign push   = accept && enc_legal;
   assign pop    = out_valid && out_ready;

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      err_pulse_d = accept && !enc_legal;
      err_count_d = err_count_q;
      if (push) begin
         mem_d[wr_ptr_q] = enc_word;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 3'd1;
         2'b01:   level_d = level_q - 3'd1;
         default: level_d = level_q;
      endcase
      if (err_pulse_d && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= 32'h0;
         end
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         level_q     <= 3'd0;
         err_pulse_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder against a queue-based reference model
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_class;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic        in_funct7b5;
   logic [20:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        err_pulse;
   logic [7:0]  err_count;
   logic [2:0]  level;

   instr_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_class   (in_class),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_funct3  (in_funct3),
      .in_funct7b5(in_funct7b5),
      .in_imm     (in_imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .level      (level)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   bit [31:0]   exp_q[$];
   bit          exp_pulse = 1'b0;
   int          exp_cnt   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference encoding built from the instruction-format rules with plain arithmetic.
   function automatic bit [31:0] ref_enc(input int cls, input int rd, input int rs1, input int rs2,
                                         input int f3, input int f7, input int imm,
                                         output bit legal);
      bit [31:0] u;
      bit [31:0] w;
      u = imm;
      w = 0;
      legal = 0;
      case (cls)
         0: begin
            legal = (imm >= -2048) && (imm <= 2047);
            w = ((u & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
         end
         1: begin
            legal = (imm >= -2048) && (imm <= 2047);
            w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
              | ((u & 'h1F) << 7) | 'h23;
         end
         2: begin
            legal = 1;
            w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
         end
         3: begin
            legal = (imm >= -4096) && (imm <= 4094) && ((u & 1) == 0);
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
              | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 'h63;
         end
         4: begin
            if (f3 == 1 || f3 == 5) begin
               legal = (imm >= 0) && (imm <= 31);
               w = (f7 << 30) | ((u & 'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end else begin
               legal = (imm >= -2048) && (imm <= 2047);
               w = ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end
         end
         5: begin
            legal = ((u & 1) == 0);
            w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
              | (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
         end
         default: legal = 0;
      endcase
      return w;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".level"}, {29'd0, level}, exp_q.size());
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_q.size() < 4});
      chk({tag, ".err_pulse"}, {31'd0, err_pulse}, {31'd0, exp_pulse});
      chk({tag, ".err_count"}, {24'd0, err_count}, exp_cnt);
      if (exp_q.size() != 0) chk({tag, ".out_instr"}, out_instr, exp_q[0]);
   endtask

   task automatic step(input string tag, input bit v, input int cls, input int rd, input int rs1,
                       input int rs2, input int f3, input int f7, input int imm, input bit ordy);
      bit        acc;
      bit        pop;
      bit        legal;
      bit [31:0] w;
      bit [31:0] dummy;
      bit [31:0] cls_b;
      bit [31:0] imm_b;
      cls_b       = cls;
      imm_b       = imm;
      in_valid    = v;
      in_class    = cls_b[2:0];
      in_rd       = rd[4:0];
      in_rs1      = rs1[4:0];
      in_rs2      = rs2[4:0];
      in_funct3   = f3[2:0];
      in_funct7b5 = f7[0];
      in_imm      = imm_b[20:0];
      out_ready   = ordy;
      w   = ref_enc(cls, rd, rs1, rs2, f3, f7, imm, legal);
      acc = v && (exp_q.size() < 4);
      pop = ordy && (exp_q.size() != 0);
      if (pop) dummy = exp_q.pop_front();
      if (acc && legal) exp_q.push_back(w);
      exp_pulse = acc && !legal;
      if (exp_pulse && exp_cnt < 255) exp_cnt++;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input bit ordy);
      step(tag, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
   endtask

   task automatic pulse_reset(input bit with_req);
      reset     = 1'b1;
      in_valid  = with_req;
      in_class  = 3'd0;
      in_imm    = 21'd4;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      exp_pulse = 1'b0;
      exp_cnt   = 0;
   endtask

   initial begin
      int cls, imm, sel;

      // Reset state
      pulse_reset(1'b1);
      chk("rst.out_instr", out_instr, 32'h0);
      check_all("rst");
      idle("post_rst", 1'b1);

      // Directed encodings, each accepted at level 0
      step("lw", 1, 0, 5, 2, 0, 0, 0, 8, 1);
      chk("lw.const", out_instr, 32'h00812283);
      idle("lw.drain", 1);
      step("rtype", 1, 2, 3, 1, 2, 0, 1, 0, 1);
      chk("rtype.const", out_instr, 32'h402081B3);
      idle("rtype.drain", 1);
      step("beq", 1, 3, 0, 1, 2, 0, 0, -4, 1);
      chk("beq.const", out_instr, 32'hFE208EE3);
      idle("beq.drain", 1);
      step("jal", 1, 5, 1, 0, 0, 0, 0, 8, 1);
      chk("jal.const", out_instr, 32'h008000EF);
      idle("jal.drain", 1);

      // Rejects
      step("rej.ialu", 1, 4, 1, 1, 0, 0, 0, 2048, 1);
      idle("rej.gap", 1);
      step("rej.beq", 1, 3, 0, 1, 2, 0, 0, 3, 1);
      idle("rej.gap2", 1);
      chk("rej.count", {24'd0, err_count}, 32'd2);

      // Boundary legality
      step("b.lw_max", 1, 0, 1, 1, 0, 0, 0, 2047, 1);
      step("b.lw_min", 1, 0, 1, 1, 0, 0, 0, -2048, 1);
      step("b.lw_lo", 1, 1, 1, 1, 1, 0, 0, -2049, 1);
      step("b.shamt31", 1, 4, 1, 1, 0, 5, 1, 31, 1);
      step("b.shamt32", 1, 4, 1, 1, 0, 1, 0, 32, 1);
      step("b.shneg", 1, 4, 1, 1, 0, 1, 0, -1, 1);
      step("b.beq_max", 1, 3, 0, 3, 4, 0, 0, 4094, 1);
      step("b.beq_min", 1, 3, 0, 3, 4, 0, 0, -4096, 1);
      step("b.beq_hi", 1, 3, 0, 3, 4, 0, 0, 4096, 1);
      step("b.jal_odd", 1, 5, 1, 0, 0, 0, 0, 9, 1);
      step("b.jal_far", 1, 5, 1, 0, 0, 0, 0, -1048576, 1);
      step("b.cls6", 1, 6, 1, 1, 1, 0, 0, 0, 1);
      step("b.cls7", 1, 7, 1, 1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) idle("b.drain", 1);

      // Backpressure: five back-to-back requests, only four fit
      for (int i = 0; i < 5; i++) step("bp.fill", 1, 0, i + 1, 2, 0, 0, 0, i * 4, 0);
      chk("bp.level4", {29'd0, level}, 32'd4);
      chk("bp.not_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) idle("bp.drain", 1);

      // Concurrent push/pop at level 2 across pointer wrap
      step("cc.fill0", 1, 2, 1, 2, 3, 0, 0, 0, 0);
      step("cc.fill1", 1, 2, 2, 2, 3, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step("cc.pp", 1, 2, i + 3, 4, 5, i % 8, i % 2, 0, 1);
      chk("cc.level2", {29'd0, level}, 32'd2);
      idle("cc.drain0", 1);
      idle("cc.drain1", 1);

      // Error counter saturation
      for (int i = 0; i < 260; i++) step("sat", 1, 7, 0, 0, 0, 0, 0, 0, 1);
      chk("sat.255", {24'd0, err_count}, 32'd255);

      // Reset mid-operation with three words queued and a request during reset
      for (int i = 0; i < 3; i++) step("mr.fill", 1, 0, i, 1, 0, 0, 0, i, 0);
      pulse_reset(1'b1);
      check_all("mr");
      chk("mr.level0", {29'd0, level}, 32'd0);
      chk("mr.cnt0", {24'd0, err_count}, 32'd0);
      chk("mr.ready", {31'd0, in_ready}, 32'd1);
      idle("mr.idle", 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cls = $urandom_range(0, 7);
         sel = $urandom_range(0, 3);
         case (sel)
            0:       imm = $urandom_range(0, 80) - 40;
            1:       imm = $urandom_range(0, 10000) - 5000;
            2:       imm = $urandom_range(0, 8) * 2 - 8 + (($urandom_range(0, 1) == 1) ? 4094 : -4090);
            default: imm = $urandom_range(0, 2097151) - 1048576;
         endcase
         step("rnd", $urandom_range(0, 3) != 0, cls, $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 1), imm,
              $urandom_range(0, 2) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  encode request present.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 in_class  input  3  0=lw, 1=sw, 2=R-type, 3=beq, 4=I-ALU, 5=jal; 6,7 illegal.
REQ-006 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-007 in_funct3  input  3  used by R-type and I-ALU only.
REQ-008 in_funct7b5  input  1  sets funct7/imm[10] = bit 5 for R-type and I-ALU shifts.
REQ-009 in_imm  input  21  signed immediate, byte offset for beq/jal.
REQ-010 out_valid  output  1  out_instr holds a valid word.
REQ-011 out_ready  input  1  consumer takes the word this cycle.
REQ-012 out_instr  output  32  encoded RV32I word at FIFO head.
REQ-013 err_pulse  output  1  one-cycle flag: request rejected.
REQ-014 err_count  output  8  saturating count of rejected requests.
REQ-015 level  output  3  FIFO occupancy, 0..4.

Function
REQ-016 Accept = in_valid && in_ready; in_ready SHALL equal (level < 4), with no dependence on out_ready.
REQ-017 Pop = out_valid && out_ready; out_valid SHALL equal (level != 0).
REQ-018 Encoding fields SHALL be as follows:
- lw: {imm[11:0], rs1, 010, rd, 0000011}.
- sw: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
- R-type: {0, f7b5, 00000, rs2, rs1, funct3, rd, 0110011}.
- beq: {imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011}.
- I-ALU: {imm[11:0], rs1, funct3, rd, 0010011}; when funct3 = 001 or 101, bits[31:25] = {0, f7b5, 00000} and bits[24:20] = imm[4:0].
- jal: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
REQ-019 Legality checks SHALL be applied as follows:
- lw, sw, non-shift I-ALU: imm in [-2048, 2047].
- shift I-ALU: imm in [0, 31].
- beq: imm in [-4096, 4094] and imm[0] = 0.
- jal: imm[0] = 0.
- class 6 or 7: always illegal.
- R-type: imm ignored.
REQ-020 An accepted legal request SHALL be written to the FIFO tail.
REQ-021 An accepted illegal request SHALL NOT be enqueued; err_pulse SHALL be 1 on the following cycle; err_count SHALL increment and saturate at 255.
REQ-022 Latency: a word accepted at edge N SHALL be visible at the head no earlier than after edge N, i.e. out_valid rises in cycle N+1 when the FIFO was empty; no combinational bypass.
REQ-023 FIFO: 4 entries, strict in-order output; out_instr SHALL be stable while out_valid && !out_ready.
REQ-024 Simultaneous push and pop SHALL leave level unchanged and preserve ordering, including at level = 4 (pop frees nothing for this cycle's push, because in_ready is already 0).
REQ-025 Read and write pointers SHALL be 2-bit and wrap 3 -> 0.
REQ-026 When out_ready = 1 at level 0, the block SHALL take no action.

Reset
REQ-027 While reset is high at an edge, the block SHALL set level = 0, both pointers = 0, out_valid = 0, out_instr = 0, err_pulse = 0 and err_count = 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued words.
REQ-029 A request presented during a reset cycle SHALL be ignored.
REQ-030 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-031 Encode checks, each accepted at level 0 -> out_valid = 1 next cycle with:
- lw rd=5, rs1=2, imm=8 -> 0x00812283.
- R-type rd=3, rs1=1, rs2=2, funct3=0, f7b5=1 -> 0x402081B3.
REQ-032 Branch and jump encode checks:
- beq rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
- jal rd=1, imm=8 -> 0x008000EF.
REQ-033 Reject check: I-ALU with imm=2048, then beq with imm=3 -> no output, err_pulse high for one cycle each, err_count = 2.
REQ-034 Backpressure check: out_ready=0, 5 back-to-back legal requests -> first 4 accepted, level = 4, in_ready = 0 on the 5th; then out_ready=1 -> 4 words out in issue order, level returns to 0.
REQ-035 Concurrent push/pop: level=2 with push and pop in the same cycle -> level stays 2 and order is preserved across pointer wrap.
REQ-036 Reset mid-operation: level=3, assert reset for 1 cycle -> level = 0, out_valid = 0, err_count = 0, in_ready = 1 on the next cycle.
